// File: rtl/sram_bank_controller.sv
// sram_bank_controller
// Splits the SRAM window into NUM_BANKS equal banks (selected by the top
// address bits) and runs a clocked 68000 bus-cycle handshake on top of it:
// registered one-hot bank selects, byte lanes, OE/WE strobes, programmable
// wait states before DTACK, and bus error for unpopulated banks.
module sram_bank_controller #(
    parameter int                   ADDR_WIDTH   = 17,
    parameter int                   NUM_BANKS    = 4,
    parameter int                   WAIT_STATES  = 1,
    parameter logic [NUM_BANKS-1:0] BANK_PRESENT = {NUM_BANKS{1'b1}}
) (
    input  logic                  Clock,
    input  logic                  Reset_H,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  SRamSelect_H,
    input  logic                  AS_L,
    input  logic                  UDS_L,
    input  logic                  LDS_L,
    input  logic                  RW,
    output logic [NUM_BANKS-1:0]  BankSel_H,
    output logic                  UpperByte_H,
    output logic                  LowerByte_H,
    output logic                  OE_L,
    output logic                  WE_L,
    output logic                  Dtack_L,
    output logic                  BErr_L,
    output logic                  Busy_H
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t               r_state;
    logic [3:0]           r_wait_cnt;
    logic [NUM_BANKS-1:0] r_bank_sel;
    logic                 r_upper_byte;
    logic                 r_lower_byte;
    logic                 r_oe_l;
    logic                 r_we_l;
    logic                 r_dtack_l;
    logic                 r_berr_l;
    logic                 r_busy;

    logic [BANK_BITS-1:0] w_bank_idx;
    logic [NUM_BANKS-1:0] w_bank_onehot;
    logic                 w_bank_present;
    logic                 w_request;
    logic                 w_addr_unused;

    // Bank index is the top BANK_BITS of the word address; the lower lines
    // address inside the bank and belong to the SRAM chips, not to us.
    assign w_bank_idx    = Address[ADDR_WIDTH-1 -: BANK_BITS];
    assign w_addr_unused = ^Address[ADDR_WIDTH-BANK_BITS-1:0];

    // One-hot decode of the bank index, one comparator per bank.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_decode
            assign w_bank_onehot[gi] = (w_bank_idx == BANK_BITS'(gi));
        end
    endgenerate

    assign w_bank_present = |(w_bank_onehot & BANK_PRESENT);

    // A bus cycle needs the window hit, address strobe and at least one data strobe.
    assign w_request = SRamSelect_H & ~AS_L & (~UDS_L | ~LDS_L);

    // Bus-cycle FSM with all outputs registered alongside the state.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 4'd0;
            r_bank_sel   <= '0;
            r_upper_byte <= 1'b0;
            r_lower_byte <= 1'b0;
            r_oe_l       <= 1'b1;
            r_we_l       <= 1'b1;
            r_dtack_l    <= 1'b1;
            r_berr_l     <= 1'b1;
            r_busy       <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_request) begin
                r_busy <= 1'b1;
                if (w_bank_present) begin
                    // Inputs are latched here; later address changes cannot move the select.
                    r_state      <= S_ACCESS;
                    r_wait_cnt   <= 4'(WAIT_STATES);
                    r_bank_sel   <= w_bank_onehot;
                    r_upper_byte <= ~UDS_L;
                    r_lower_byte <= ~LDS_L;
                    r_oe_l       <= ~RW;
                    r_we_l       <= RW;
                end else begin
                    r_state  <= S_ERROR;
                    r_berr_l <= 1'b0;
                end
            end
        end else if (AS_L) begin
            // Address strobe released: ends ACK/ERROR normally, aborts ACCESS.
            r_state      <= S_IDLE;
            r_wait_cnt   <= 4'd0;
            r_bank_sel   <= '0;
            r_upper_byte <= 1'b0;
            r_lower_byte <= 1'b0;
            r_oe_l       <= 1'b1;
            r_we_l       <= 1'b1;
            r_dtack_l    <= 1'b1;
            r_berr_l     <= 1'b1;
            r_busy       <= 1'b0;
        end else if (r_state == S_ACCESS) begin
            if (r_wait_cnt == 4'd0) begin
                r_state   <= S_ACK;
                r_dtack_l <= 1'b0;
            end else begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    assign BankSel_H   = r_bank_sel;
    assign UpperByte_H = r_upper_byte;
    assign LowerByte_H = r_lower_byte;
    assign OE_L        = r_oe_l;
    assign WE_L        = r_we_l;
    assign Dtack_L     = r_dtack_l;
    assign BErr_L      = r_berr_l;
    assign Busy_H      = r_busy;

endmodule

// File: tb/tb_sram_bank_controller.sv
// Testbench for sram_bank_controller: four differently configured instances
// share one stimulus stream; each is compared every cycle against a
// transaction-level model (active / error / cycles since request).
module tb_sram_bank_controller;

    localparam int NDUT   = 4;
    localparam int ASPACE = 131072;  // 2**17 word addresses

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] addr;
    logic        sel, as_l, uds_l, lds_l, rw;

    logic [3:0] sel0, sel2, sel3;
    logic [7:0] sel1;
    logic       ub[NDUT], lb[NDUT], oe[NDUT], we[NDUT], dt[NDUT], be[NDUT], bz[NDUT];
    logic [15:0] g_sel[NDUT];

    // Instance configurations
    int          p_nb[NDUT]   = '{4, 8, 4, 4};
    int          p_ws[NDUT]   = '{1, 0, 1, 3};
    logic [15:0] p_pres[NDUT] = '{16'h000F, 16'h00FF, 16'h0007, 16'h000F};

    // Reference model state
    bit m_act[NDUT], m_err[NDUT], m_rw[NDUT], m_uds[NDUT], m_lds[NDUT];
    int m_k[NDUT], m_bank[NDUT];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_bank_controller u0 (
        .Clock(clk), .Reset_H(rst), .Address(addr), .SRamSelect_H(sel), .AS_L(as_l),
        .UDS_L(uds_l), .LDS_L(lds_l), .RW(rw), .BankSel_H(sel0), .UpperByte_H(ub[0]),
        .LowerByte_H(lb[0]), .OE_L(oe[0]), .WE_L(we[0]), .Dtack_L(dt[0]), .BErr_L(be[0]),
        .Busy_H(bz[0]));

    sram_bank_controller #(.NUM_BANKS(8), .WAIT_STATES(0)) u1 (
        .Clock(clk), .Reset_H(rst), .Address(addr), .SRamSelect_H(sel), .AS_L(as_l),
        .UDS_L(uds_l), .LDS_L(lds_l), .RW(rw), .BankSel_H(sel1), .UpperByte_H(ub[1]),
        .LowerByte_H(lb[1]), .OE_L(oe[1]), .WE_L(we[1]), .Dtack_L(dt[1]), .BErr_L(be[1]),
        .Busy_H(bz[1]));

    sram_bank_controller #(.BANK_PRESENT(4'b0111)) u2 (
        .Clock(clk), .Reset_H(rst), .Address(addr), .SRamSelect_H(sel), .AS_L(as_l),
        .UDS_L(uds_l), .LDS_L(lds_l), .RW(rw), .BankSel_H(sel2), .UpperByte_H(ub[2]),
        .LowerByte_H(lb[2]), .OE_L(oe[2]), .WE_L(we[2]), .Dtack_L(dt[2]), .BErr_L(be[2]),
        .Busy_H(bz[2]));

    sram_bank_controller #(.WAIT_STATES(3)) u3 (
        .Clock(clk), .Reset_H(rst), .Address(addr), .SRamSelect_H(sel), .AS_L(as_l),
        .UDS_L(uds_l), .LDS_L(lds_l), .RW(rw), .BankSel_H(sel3), .UpperByte_H(ub[3]),
        .LowerByte_H(lb[3]), .OE_L(oe[3]), .WE_L(we[3]), .Dtack_L(dt[3]), .BErr_L(be[3]),
        .Busy_H(bz[3]));

    assign g_sel[0] = {12'b0, sel0};
    assign g_sel[1] = {8'b0, sel1};
    assign g_sel[2] = {12'b0, sel2};
    assign g_sel[3] = {12'b0, sel3};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model one bus-cycle step using the inputs the DUTs just sampled.
    task automatic model_step();
        logic [15:0] pres;
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                m_act[d] = 0;
            end else if (!m_act[d]) begin
                if (sel && !as_l && (!uds_l || !lds_l)) begin
                    m_act[d]  = 1;
                    m_k[d]    = 0;
                    m_bank[d] = int'(addr) / (ASPACE / p_nb[d]);
                    pres      = p_pres[d];
                    m_err[d]  = !pres[m_bank[d]];
                    m_rw[d]   = rw;
                    m_uds[d]  = uds_l;
                    m_lds[d]  = lds_l;
                end
            end else if (as_l) begin
                m_act[d] = 0;
            end else begin
                m_k[d]++;
            end
        end
    endtask

    task automatic check_all();
        logic [15:0] e_sel;
        bit ok;
        for (int d = 0; d < NDUT; d++) begin
            ok    = m_act[d] && !m_err[d];
            e_sel = ok ? (16'h1 << m_bank[d]) : 16'h0;
            check_eq($sformatf("u%0d_sel", d), 32'(g_sel[d]), 32'(e_sel));
            check_eq($sformatf("u%0d_oe", d), 32'(oe[d]), ok ? 32'(!m_rw[d]) : 32'd1);
            check_eq($sformatf("u%0d_we", d), 32'(we[d]), ok ? 32'(m_rw[d]) : 32'd1);
            check_eq($sformatf("u%0d_dtack", d), 32'(dt[d]),
                     (ok && m_k[d] >= p_ws[d] + 1) ? 32'd0 : 32'd1);
            check_eq($sformatf("u%0d_berr", d), 32'(be[d]), (m_act[d] && m_err[d]) ? 32'd0 : 32'd1);
            check_eq($sformatf("u%0d_busy", d), 32'(bz[d]), 32'(m_act[d]));
            if (!(m_act[d] && m_err[d])) begin
                check_eq($sformatf("u%0d_ub", d), 32'(ub[d]), ok ? 32'(!m_uds[d]) : 32'd0);
                check_eq($sformatf("u%0d_lb", d), 32'(lb[d]), ok ? 32'(!m_lds[d]) : 32'd0);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic start(input logic [16:0] a, input logic r, input logic u, input logic l);
        addr = a; rw = r; uds_l = u; lds_l = l; sel = 1'b1; as_l = 1'b0;
        cyc();
    endtask

    task automatic release_bus(input int gap);
        as_l = 1'b1; uds_l = 1'b1; lds_l = 1'b1; sel = 1'b0;
        repeat (gap) cyc();
    endtask

    initial begin
        rst = 1'b1; addr = '0; sel = 1'b0; as_l = 1'b1; uds_l = 1'b1; lds_l = 1'b1; rw = 1'b1;
        repeat (2) cyc();
        check_eq("reset_dtack", 32'(dt[0]), 32'd1);
        rst = 1'b0;
        cyc();

        // Read, both strobes, bank 2 of 4
        start(17'h10000, 1'b1, 1'b0, 1'b0);
        check_eq("rd_sel_u0", 32'(sel0), 32'h4);
        check_eq("rd_oe_u0", 32'(oe[0]), 32'd0);
        cyc();
        check_eq("rd_dtack_u0_n1", 32'(dt[0]), 32'd1);
        cyc();
        check_eq("rd_dtack_u0_n2", 32'(dt[0]), 32'd0);
        cyc();
        release_bus(2);

        // Write, UDS only, top bank of 8 with zero wait states
        start(17'h1C000, 1'b0, 1'b0, 1'b1);
        check_eq("wr_sel_u1", 32'(sel1), 32'h80);
        check_eq("wr_we_u1", 32'(we[1]), 32'd0);
        check_eq("wr_ub_u1", 32'(ub[1]), 32'd1);
        cyc();
        check_eq("wr_dtack_u1_n1", 32'(dt[1]), 32'd0);
        release_bus(2);

        // Absent bank on u2
        start(17'h18000, 1'b1, 1'b0, 1'b0);
        check_eq("err_berr_u2", 32'(be[2]), 32'd0);
        check_eq("err_sel_u2", 32'(sel2), 32'd0);
        repeat (3) cyc();
        check_eq("err_dtack_u2", 32'(dt[2]), 32'd1);
        release_bus(1);
        check_eq("err_idle_u2", 32'(bz[2]), 32'd0);

        // Abort after 2 ACCESS cycles on u3, address and select changed mid-cycle
        start(17'h08000, 1'b1, 1'b0, 1'b0);
        addr = 17'h18000; sel = 1'b0;
        cyc();
        check_eq("abort_sel_u3", 32'(sel3), 32'h2);
        release_bus(1);
        check_eq("abort_dtack_u3", 32'(dt[3]), 32'd1);
        check_eq("abort_busy_u3", 32'(bz[3]), 32'd0);
        cyc();

        // Back-to-back: bank 0 then bank 3 with one idle cycle
        start(17'h00000, 1'b1, 1'b0, 1'b0);
        repeat (4) cyc();
        release_bus(1);
        start(17'h18000, 1'b1, 1'b0, 1'b0);
        check_eq("b2b_sel_u0", 32'(sel0), 32'h8);
        repeat (4) cyc();
        release_bus(1);

        // Reset held 3 cycles in the middle of an ACCESS
        start(17'h04000, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (3) cyc();
        check_eq("rst_busy_u3", 32'(bz[3]), 32'd0);
        check_eq("rst_we_u3", 32'(we[3]), 32'd1);
        rst = 1'b0;
        release_bus(2);

        // Randomized bus cycles
        for (int t = 0; t < 300; t++) begin
            int hold;
            hold = int'($urandom_range(1, 7));
            addr  = 17'($urandom);
            rw    = 1'($urandom);
            uds_l = 1'($urandom);
            lds_l = 1'($urandom);
            sel   = ($urandom_range(0, 7) != 0);
            as_l  = 1'b0;
            for (int h = 0; h < hold; h++) begin
                cyc();
                if ($urandom_range(0, 3) == 0) addr = 17'($urandom);
                if ($urandom_range(0, 5) == 0) sel = ~sel;
            end
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
            end
            release_bus(int'($urandom_range(1, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_bank_controller.md
Name: sram_bank_controller

Overview:
- Parametrised successor to the fixed four-block SRAM decoder.
- Splits the SRAM window into NUM_BANKS equal banks selected by the top address bits.
- Adds a clocked 68000 bus-cycle handshake: registered bank selects, byte lanes, OE/WE strobes, programmable wait states, DTACK generation, and bus error for unpopulated banks.
- Sits between the top-level address decoder (SRamSelect_H) and the SRAM chip-enable/strobe pins.

Parameters:
- ADDR_WIDTH, 17: number of 68k address lines seen by the block (word address, A0 absent).
- NUM_BANKS, 4: bank count. Power of two, 2..16. BANK_BITS = log2(NUM_BANKS).
- WAIT_STATES, 1: extra clocks inserted before DTACK. Range 0..15.
- BANK_PRESENT, all ones (NUM_BANKS bits): bit i = 1 means bank i is populated. An access to a clear bit produces bus error.

Ports:
- Clock, input, 1: system clock; all state changes on rising edge.
- Reset_H, input, 1: synchronous, active-high reset.
- Address, input, ADDR_WIDTH: 68k address bus, lower lines.
- SRamSelect_H, input, 1: top-level decode, SRAM window hit.
- AS_L, input, 1: 68k address strobe.
- UDS_L, input, 1: upper data strobe.
- LDS_L, input, 1: lower data strobe.
- RW, input, 1: 1 = read, 0 = write.
- BankSel_H, output, NUM_BANKS: one-hot bank select.
- UpperByte_H, output, 1: upper byte lane enable.
- LowerByte_H, output, 1: lower byte lane enable.
- OE_L, output, 1: SRAM output enable.
- WE_L, output, 1: SRAM write enable.
- Dtack_L, output, 1: data transfer acknowledge to 68k.
- BErr_L, output, 1: bus error to 68k.
- Busy_H, output, 1: high whenever state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (sampled at any edge, in any state):
  - Next state is IDLE.
  - BankSel_H = 0, UpperByte_H = 0, LowerByte_H = 0.
  - OE_L = 1, WE_L = 1, Dtack_L = 1, BErr_L = 1, Busy_H = 0.
  - Wait counter = 0.
  - Reset overrides every request.
- Request condition: SRamSelect_H = 1 and AS_L = 0 and (UDS_L = 0 or LDS_L = 0). The request is sampled only in IDLE.
- Bank index: Address[ADDR_WIDTH-1 : ADDR_WIDTH-BANK_BITS], latched at request. Address changes later in the cycle are ignored. RW, UDS_L and LDS_L are latched at the same edge.
- IDLE:
  - Outputs are at their reset values.
  - On a request to a present bank: go to ACCESS and load the counter with WAIT_STATES.
  - On a request to an absent bank: go to ERROR.
- ACCESS:
  - BankSel_H[index] = 1 (one-hot).
  - UpperByte_H = ~UDS_L latched; LowerByte_H = ~LDS_L latched.
  - OE_L = ~RW latched; WE_L = RW latched.
  - Counter = 0 goes to ACK; otherwise decrement and stay.
  - ACCESS lasts exactly WAIT_STATES+1 cycles.
  - If AS_L = 1 is sampled in ACCESS (aborted cycle): go to IDLE, all outputs inactive next edge, Dtack_L never asserted.
- ACK:
  - Dtack_L = 0; selects, byte lanes, OE_L and WE_L held.
  - Stay until AS_L = 1 is sampled, then go to IDLE; all outputs inactive on that edge.
- ERROR:
  - BErr_L = 0; BankSel_H = 0, OE_L = 1, WE_L = 1.
  - Stay until AS_L = 1 is sampled, then go to IDLE.
- Latency: request sampled at edge N gives BankSel_H valid after N. Dtack_L goes low after edge N+WAIT_STATES+1. BErr_L goes low after edge N.
- Back-to-back cycles: leaving ACK or ERROR requires AS_L = 1. A new request is therefore honoured only from IDLE, at the earliest one cycle after release.
- SRamSelect_H dropping mid-cycle is ignored; the cycle is governed by AS_L only.
- BankSel_H is never multi-hot. Dtack_L and BErr_L are never low simultaneously.

Test Plan:
- Reset held 3 cycles mid-ACCESS -> every output at reset value on the next edge; Busy_H = 0.
- Defaults; Address = 17'h10000, read, both strobes -> BankSel_H = 4'b0100 after edge N; OE_L = 0, WE_L = 1; Dtack_L low after edge N+2; AS_L high -> all inactive next edge.
- WAIT_STATES = 0, NUM_BANKS = 8, Address = 17'h1C000, write, UDS_L only -> BankSel_H = 8'h80; WE_L = 0; UpperByte_H = 1, LowerByte_H = 0; Dtack_L low after N+1.
- BANK_PRESENT = 4'b0111, Address = 17'h18000 -> BErr_L low after N; BankSel_H = 0; Dtack_L stays 1; IDLE after AS_L high.
- WAIT_STATES = 3; AS_L released after 2 ACCESS cycles -> IDLE, Dtack_L never low. Address changed mid-cycle -> BankSel_H unchanged.
- Back-to-back reads to banks 0 then 3 with one idle AS_L-high cycle -> correct one-hot per cycle; no overlap of selects.
